fetch_controller: RTL
=====================

Name: fetch_controller

Overview:
- Sequences the word-indexed, combinationally-read instruction memory. Owns the program counter and drives the memory's word address every cycle.
- Captures returned instructions into a small FIFO. Delivers them to decode over a valid/ready handshake.
- Handles branch redirects from execute and stops fetching when the memory flags end of program.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC at reset
- QDEPTH, 2, instruction queue entries (power of two, >=2)
- PTR_W, 1, log2(QDEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; leaves IDLE and begins fetching
- imem_pc  out  32  word index to instruction memory = pc[31:2], zero-extended
- imem_instr  in  32  instruction returned combinationally for imem_pc
- imem_done  in  1  memory reports no valid instruction at imem_pc (end of program)
- redirect_valid  in  1  branch/jump taken; flush and refetch
- redirect_pc  in  32  redirect byte target; bits [1:0] ignored
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_instr  out  32  head instruction
- out_pc  out  32  head byte PC
- halted  out  1  end of program reached and queue drained
- fetch_cnt  out  32  instructions enqueued since reset, wraps modulo 2^32

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, queue empty, fetch_cnt=0.
  - Outputs: out_valid=0, halted=0, imem_pc=RESET_PC[31:2]. out_instr and out_pc are 0.
- States:
  - IDLE: no enqueue. start -> FETCH.
  - FETCH: enqueue when space is available.
  - DRAIN: end of program seen, no further enqueue.
  - HALT: halted=1.
- Space rule: space = (count < QDEPTH) or (out_valid and out_ready). Same-cycle pop plus push at full is allowed.
- FETCH, each cycle with space and no redirect:
  - imem_done=0: push {imem_instr, pc}; pc <= pc+4; fetch_cnt++.
  - imem_done=1: no push, pc held, -> DRAIN.
- FETCH without space: pc held (stall). imem_pc stays stable.
- Latency: instruction visible on out_* one cycle after its address is presented, given space. Sustained throughput is 1 instr/cycle with out_ready=1.
- Pop: head removed on out_valid and out_ready. out_instr and out_pc are registered FIFO head outputs, driven directly from storage.
- DRAIN: pops continue. When count reaches 0 (after that cycle's pop) -> HALT.
- HALT: halted=1, out_valid=0. Stays until redirect or reset. start is ignored.
- Redirect (highest priority, any state except IDLE):
  - Queue flushed (count=0, pointers reset). Any same-cycle pop or push is discarded.
  - pc <= {redirect_pc[31:2],2'b00}; state -> FETCH; halted deasserts next cycle.
  - out_valid=0 the cycle after a redirect. The first redirected instruction appears the cycle after that.
  - Redirect in IDLE is ignored.
- start while not in IDLE: ignored.
- PC arithmetic: 32-bit wrap (32'hFFFF_FFFC+4 -> 0).
- Counts: queue count is PTR_W+1 bits. Full when count==QDEPTH. Pointers wrap modulo QDEPTH.
- halted and out_valid are never both 1.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32.
  - Fetch state encoding: IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, HALT=2'd3.
  - INSTR_W.
- Sub-module fetch_queue: synchronous FIFO with push/pop/flush, count, head data. Parameterised by QDEPTH and data width 64 ({pc, instr}).
- fetch_controller holds the state machine, PC register and counter.

Test Plan:
- Reset, start, memory words 0..3 valid, word 4 done, out_ready=1:
  - Required: out_pc sequence 0,4,8,12 on consecutive cycles.
  - Then halted=1 two cycles after the last pop; fetch_cnt=4.
- Backpressure, out_ready=0 from start:
  - Required: queue fills after 2 pushes; imem_pc holds at 2; out_instr holds word 0.
  - Raise out_ready: pops resume with no lost or duplicated instruction.
- Redirect, redirect_valid with redirect_pc=32'h0000_0043 while queue holds 2 entries:
  - Required: out_valid=0 next cycle; imem_pc=16 (word index of 0x40); next out_pc=32'h40.
  - fetch_cnt excludes flushed entries never popped? No: fetch_cnt counts pushes, so it is unchanged by the flush.
- Redirect in HALT to pc=0:
  - Required: halted drops next cycle and fetch restarts from word 0.
- Asynchronous reset asserted mid-fetch, away from a clock edge:
  - Required: out_valid, halted and fetch_cnt go to 0 immediately.
  - After release, state is IDLE and nothing is fetched until start.
- Simultaneous pop and push at full (QDEPTH=2, out_ready=1):
  - Required: count stays 2 and order is preserved.
  - pc=32'hFFFF_FFFC wraps to 0 after a push.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and fetch state encoding
package cpu_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO of {pc, instr} with flush and head read from storage
module fetch_queue #(
    parameter int QDEPTH = 2,
    parameter int PTR_W  = 1,
    parameter int W      = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic           pop,
    input  logic           flush,
    input  logic [W-1:0]   wdata,
    output logic [W-1:0]   head,
    output logic [PTR_W:0] count
);
    logic [W-1:0]     mem [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    // storage, pointers and occupancy; flush beats any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: PC sequencing, instruction queueing, redirect and end-of-program handling
module fetch_controller
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter int          PTR_W    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [XLEN-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               imem_done,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               halted,
    output logic [31:0]        fetch_cnt
);
    fetch_state_t                state, state_nx;
    logic [XLEN-1:0]             pc, pc_nx;
    logic [PTR_W:0]              count;
    logic [XLEN+INSTR_W-1:0]     head;
    logic                        redir, pop, push, space;

    assign redir     = redirect_valid && state != IDLE;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready && !redir;
    assign space     = count < (PTR_W+1)'(QDEPTH) || (out_valid && out_ready);
    assign push      = state == FETCH && space && !imem_done && !redir;
    assign halted    = state == HALT;
    assign imem_pc   = {2'b00, pc[XLEN-1:2]};
    assign out_pc    = head[XLEN+INSTR_W-1:INSTR_W];
    assign out_instr = head[INSTR_W-1:0];

    fetch_queue #(.QDEPTH(QDEPTH), .PTR_W(PTR_W), .W(XLEN+INSTR_W)) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .wdata ({pc, imem_instr}),
        .head  (head),
        .count (count)
    );

    // next state and pc: redirect wins, otherwise advance only when a push happens
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        if (redir) begin
            state_nx = FETCH;
            pc_nx    = redirect_pc & ~32'd3;
        end else begin
            case (state)
                IDLE:    state_nx = start ? FETCH : IDLE;
                FETCH:   if (space) begin
                             if (imem_done) state_nx = DRAIN;
                             else pc_nx = pc + 32'd4;
                         end
                DRAIN:   state_nx = (count == (PTR_W+1)'(pop)) ? HALT : DRAIN;
                default: state_nx = state;
            endcase
        end
    end

    // state, pc and enqueue counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            fetch_cnt <= fetch_cnt + 32'(push);
        end
    end
endmodule
